spi_slave_rx: RTL

SPI slave receiver in the system clock domain, directly downstream of the SPI master: consumes its SCLK/MOSI/SS lines and turns each complete frame byte into a parallel word. Output uses a valid/ready handshake. SCLK, MOSI and SS are oversampled through synchronizers, so the master's divided SCLK must be slow relative to clk. Flags partial frames and overruns for the loopback test harness.

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_slave_rx_if.sv | 26 ++
 rtl/spi_sync.sv | 23 ++
 rtl/spi_slave_rx.sv | 122 ++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: receiver FSM encoding, SPI mode constants and
// the default word width, also used by the SPI master.
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t SPI_MODE0 = '{cpol: 1'b0, cpha: 1'b0};
  localparam spi_mode_t SPI_MODE1 = '{cpol: 1'b0, cpha: 1'b1};
  localparam spi_mode_t SPI_MODE2 = '{cpol: 1'b1, cpha: 1'b0};
  localparam spi_mode_t SPI_MODE3 = '{cpol: 1'b1, cpha: 1'b1};

  // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling one.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return (cpol ^ cpha) == 1'b0;
  endfunction

endpackage

// File: rtl/spi_slave_rx_if.sv
// Pin and word-handshake bundle of the SPI slave receiver; the slave modport
// is the receiver's view, the master modport the driving environment's view.
interface spi_slave_rx_if import spi_pkg::*; #(
  parameter int DATA_W = SPI_DATA_W
);
  logic              SCLK;
  logic              MOSI;
  logic              SS;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              busy;
  logic              frame_err;
  logic              overrun;
  logic              ovr_clr;

  modport slave (
    input  SCLK, MOSI, SS, rx_ready, ovr_clr,
    output rx_data, rx_valid, busy, frame_err, overrun
  );

  modport master (
    output SCLK, MOSI, SS, rx_ready, ovr_clr,
    input  rx_data, rx_valid, busy, frame_err, overrun
  );
endinterface

// File: rtl/spi_sync.sv
// Flop-chain synchronizer for one asynchronous SPI pin, preset to RST_VAL so
// that reset never fabricates an edge on the synced line.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= {STAGES{RST_VAL}};
    else      sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: oversamples SCLK/MOSI/SS in the clk domain, assembles
// words and hands them out over valid/ready, flagging partial frames and overruns.
module spi_slave_rx import spi_pkg::*; #(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           rst,
  spi_slave_rx_if.slave bus
);
  localparam int   CNT_W    = $clog2(DATA_W);
  localparam logic IDLE_LVL = (CPOL != 0);
  localparam logic ON_RISE  = sample_on_rise(CPOL != 0, CPHA != 0);

  logic sclk_s, mosi_s, ss_s;
  logic sclk_prev_q, sclk_prev_d;
  logic sample_edge, word_done, overrun_set;
  logic [DATA_W-1:0] next_word;

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0] shift_q, shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(IDLE_LVL)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(bus.SCLK), .q(sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(bus.MOSI), .q(mosi_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst(rst), .d(bus.SS), .q(ss_s)
  );

  // The incoming bit is merged combinationally so a finished word loads without an extra cycle.
  always_comb begin
    sclk_prev_d = sclk_s;
    sample_edge = ON_RISE ? (sclk_s & ~sclk_prev_q) : (~sclk_s & sclk_prev_q);
    next_word   = (MSB_FIRST != 0) ? {shift_q, mosi_s} : {mosi_s, shift_q};
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    word_done   = 1'b0;
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (!ss_s) state_d = SHIFT;
      end
      SHIFT: begin
        if (ss_s) begin
          state_d     = IDLE;
          bit_cnt_d   = '0;
          shift_d     = '0;
          frame_err_d = (bit_cnt_q != '0);
        end else if (sample_edge) begin
          shift_d = (MSB_FIRST != 0) ? next_word[DATA_W-2:0] : next_word[DATA_W-1:1];
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            word_done = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A full holding register that is not being drained drops the new word; set beats clear.
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_set = 1'b0;
    if (word_done && (!rx_valid_q || bus.rx_ready)) begin
      rx_data_d  = next_word;
      rx_valid_d = 1'b1;
    end else if (word_done) begin
      overrun_set = 1'b1;
    end else if (rx_valid_q && bus.rx_ready) begin
      rx_valid_d = 1'b0;
    end
    overrun_d = overrun_set | (overrun_q & ~bus.ovr_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_prev_q <= IDLE_LVL;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.busy      = (state_q == SHIFT);
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
endmodule
